// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared constants and types for the DAC SPI receiver.
//   Frame layout, MSB first: {4'b0000, data[7:0], 4'b0000}.
package dac_spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_MSB   = 11;
    localparam int DATA_LSB   = 4;
    localparam int DATA_W     = 8;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_SHORT = 2'd1,
        ERR_LONG  = 2'd2,
        ERR_PAD   = 2'd3
    } err_code_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // True when either pad nibble of a frame is non-zero.
    function automatic logic pad_bad(input logic [FRAME_BITS-1:0] word);
        return (word[15:12] != 4'h0) || (word[3:0] != 4'h0);
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: input register chain plus one history register, with edge detect.
//   clk, rst_n : system clock, synchronous active-low reset
//   din        : raw pin
//   level      : last chain stage
//   rise, fall : level differs from history (combinational from registers)
module spi_in_sync
    import dac_spi_pkg::*;
#(
    parameter int   STAGES  = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            hist  <= RST_VAL;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            hist <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/dac_spi_rx.sv
// dac_spi_rx: SPI receiver / checker for 16-bit DAC frames.
//   clk, rst_n          : system clock, synchronous active-low reset
//   dac_sync/sclk/sdi   : SPI pins (sync active low, sclk idle low, MSB first)
//   rx_word             : last complete frame (good or bad)
//   rx_data             : data byte of the last good frame
//   rx_valid / rx_err   : one-cycle pulse per good / bad frame
//   err_code            : result of the last frame, held until the next one
//   good_cnt / err_cnt  : good frames (wrapping) / bad frames (saturating)
//
// state | meaning
// IDLE  | waiting for a sync fall while armed
// SHIFT | frame active, shifting sdi on sclk rises
module dac_spi_rx #(
    parameter int SYNC_STAGES = 1,
    parameter bit CHECK_PAD   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dac_sync,
    input  logic        dac_sclk,
    input  logic        dac_sdi,
    output logic [15:0] rx_word,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_err,
    output logic [1:0]  err_code,
    output logic [15:0] good_cnt,
    output logic [7:0]  err_cnt
);
    import dac_spi_pkg::*;

    logic sync_lvl, sync_rise, sync_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
        .clk(clk), .rst_n(rst_n), .din(dac_sync),
        .level(sync_lvl), .rise(sync_rise), .fall(sync_fall)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .din(dac_sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
        .clk(clk), .rst_n(rst_n), .din(dac_sdi),
        .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
    );

    logic unused_edges;
    assign unused_edges = &{1'b0, sclk_lvl, sclk_fall, sdi_rise, sdi_fall};

    state_t            state;
    logic              armed;
    logic [3:0]        fill_cnt;
    logic              primed;
    logic [15:0]       shreg;
    logic [4:0]        bit_cnt;
    logic              overrun;
    logic              done;
    logic [15:0]       done_word;
    err_code_t         done_code;
    err_code_t         frame_code;

    // The sync pipe holds its reset value until real pin samples reach the
    // last stage; arming on that reset value would accept a frame that was
    // already in progress when reset was released.
    assign primed = (fill_cnt == 4'(SYNC_STAGES));

    always_comb begin
        frame_code = ERR_NONE;
        if (bit_cnt < 5'(FRAME_BITS)) begin
            frame_code = ERR_SHORT;
        end else if (overrun) begin
            frame_code = ERR_LONG;
        end else if (CHECK_PAD && pad_bad(shreg)) begin
            frame_code = ERR_PAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            fill_cnt  <= 4'd0;
            shreg     <= 16'h0000;
            bit_cnt   <= 5'd0;
            overrun   <= 1'b0;
            done      <= 1'b0;
            done_word <= 16'h0000;
            done_code <= ERR_NONE;
            rx_word   <= 16'h0000;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            err_code  <= 2'd0;
            good_cnt  <= 16'h0000;
            err_cnt   <= 8'h00;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            done     <= 1'b0;

            if (!primed) begin
                fill_cnt <= fill_cnt + 4'd1;
            end
            if (primed && sync_lvl) begin
                armed <= 1'b1;
            end

            // Frame result is captured separately so the next frame may
            // clear shreg on the very next edge (1-clk sync-high gap).
            if (done) begin
                rx_word  <= done_word;
                err_code <= done_code;
                if (done_code == ERR_NONE) begin
                    rx_valid <= 1'b1;
                    rx_data  <= done_word[DATA_MSB:DATA_LSB];
                    good_cnt <= good_cnt + 16'd1;
                end else begin
                    rx_err <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (sync_fall && armed) begin
                        state   <= SHIFT;
                        bit_cnt <= 5'd0;
                        shreg   <= 16'h0000;
                        overrun <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sync_rise) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        done_word <= shreg;
                        done_code <= frame_code;
                    end else if (sclk_rise) begin
                        if (bit_cnt < 5'(FRAME_BITS)) begin
                            shreg   <= {shreg[14:0], sdi_lvl};
                            bit_cnt <= bit_cnt + 5'd1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_rx.sv
// Bench for dac_spi_rx: two instances (pad check on / off) share the pins.
// A frame-level model predicts every output on every cycle.
module tb_dac_spi_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dac_sync = 1'b1;
    logic dac_sclk = 1'b0;
    logic dac_sdi = 1'b0;

    logic [15:0] rx_word  [2];
    logic [7:0]  rx_data  [2];
    logic        rx_valid [2];
    logic        rx_err   [2];
    logic [1:0]  err_code [2];
    logic [15:0] good_cnt [2];
    logic [7:0]  err_cnt  [2];

    always #5 clk = ~clk;

    dac_spi_rx #(.SYNC_STAGES(1), .CHECK_PAD(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .dac_sync(dac_sync), .dac_sclk(dac_sclk), .dac_sdi(dac_sdi),
        .rx_word(rx_word[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_err(rx_err[0]),
        .err_code(err_code[0]), .good_cnt(good_cnt[0]), .err_cnt(err_cnt[0])
    );
    dac_spi_rx #(.SYNC_STAGES(1), .CHECK_PAD(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .dac_sync(dac_sync), .dac_sclk(dac_sclk), .dac_sdi(dac_sdi),
        .rx_word(rx_word[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_err(rx_err[1]),
        .err_code(err_code[1]), .good_cnt(good_cnt[1]), .err_cnt(err_cnt[1])
    );

    int n_pass = 0;
    int n_total = 0;

    int   cyc = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    // One entry per completed frame: cycle the result must appear, rises sent, word sent.
    typedef struct {
        int          due;
        int          nbits;
        logic [15:0] sent;
    } ev_t;
    ev_t evq[$];

    logic [15:0] m_word [2];
    logic [7:0]  m_data [2];
    logic [1:0]  m_code [2];
    logic [15:0] m_good [2];
    logic [7:0]  m_err  [2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_word[i] = 0; m_data[i] = 0; m_code[i] = 0; m_good[i] = 0; m_err[i] = 0;
        end
    endtask

    initial model_clear();

    always @(negedge clk) begin
        logic [1:0]  pv, pe;
        logic [51:0] got, exp;
        ev_t         ev;
        logic [15:0] w;
        int          code;
        pv = 2'b00;
        pe = 2'b00;
        if (!rst_seen) begin
            model_clear();
            evq.delete();
        end else begin
            while (evq.size() > 0 && evq[0].due == cyc) begin
                ev = evq.pop_front();
                // Register contents = the first min(n,16) bits received.
                w = (ev.nbits >= 16) ? ev.sent : (ev.sent >> (16 - ev.nbits));
                for (int i = 0; i < 2; i++) begin
                    if (ev.nbits < 16)      code = 1;
                    else if (ev.nbits > 16) code = 2;
                    else if (i == 0 && ((w / 4096) != 0 || (w % 16) != 0)) code = 3;
                    else                    code = 0;
                    m_word[i] = w;
                    m_code[i] = 2'(code);
                    if (code == 0) begin
                        pv[i] = 1'b1;
                        m_data[i] = 8'((w / 16) % 256);
                        m_good[i] = m_good[i] + 16'd1;
                    end else begin
                        pe[i] = 1'b1;
                        if (m_err[i] < 8'd255) m_err[i] = m_err[i] + 8'd1;
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            got = {rx_valid[i], rx_err[i], rx_word[i], rx_data[i], err_code[i], good_cnt[i], err_cnt[i]};
            exp = {pv[i], pe[i], m_word[i], m_data[i], m_code[i], m_good[i], m_err[i]};
            n_total++;
            if (got === exp) n_pass++;
            else $display("FAIL cycle_model dut%0d cyc=%0d got v=%b e=%b word=%h data=%h code=%0d good=%0d err=%0d expected v=%b e=%b word=%h data=%h code=%0d good=%0d err=%0d",
                          i, cyc, got[51], got[50], got[49:34], got[33:26], got[25:24], got[23:8], got[7:0],
                          exp[51], exp[50], exp[49:34], exp[33:26], exp[25:24], exp[23:8], exp[7:0]);
        end
    end

    task automatic check_lit(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h expected %h", name, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] w, input int first, input int last);
        for (int i = first; i < last; i++) begin
            dac_sdi = (i < 16) ? w[15 - i] : 1'b0;
            @(negedge clk) dac_sclk = 1'b1;
            @(negedge clk) dac_sclk = 1'b0;
        end
    endtask

    // Sync falls, n sclk pulses, sync rises and stays high for one clk.
    task automatic send_frame(input logic [15:0] w, input int n);
        ev_t ev;
        @(negedge clk);
        dac_sync = 1'b0;
        dac_sclk = 1'b0;
        send_bits(w, 0, n);
        dac_sync = 1'b1;
        ev.due = cyc + 3;
        ev.nbits = n;
        ev.sent = w;
        evq.push_back(ev);
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(3);
        check_lit("reset_word", rx_word[0], 16'h0000);
        check_lit("reset_good", good_cnt[0], 16'h0000);

        // 1: single good frame
        send_frame(16'h0A50, 16);
        idle(4);
        check_lit("t1_data", {8'h00, rx_data[0]}, 16'h00A5);
        check_lit("t1_word", rx_word[0], 16'h0A50);
        check_lit("t1_good", good_cnt[0], 16'd1);

        // 2: back-to-back frames with one-clk sync-high gap
        send_frame(16'h0000, 16);
        send_frame(16'h0FF0, 16);
        idle(4);
        check_lit("t2_data", {8'h00, rx_data[0]}, 16'h00FF);
        check_lit("t2_good", good_cnt[0], 16'd3);

        // 3: short then long frame
        send_frame(16'h0ABC, 12);
        idle(4);
        check_lit("t3_short_code", {14'd0, err_code[0]}, 16'd1);
        check_lit("t3_short_cnt", {8'h00, err_cnt[0]}, 16'd1);
        check_lit("t3_short_data", {8'h00, rx_data[0]}, 16'h00FF);
        send_frame(16'h0120, 17);
        idle(4);
        check_lit("t3_long_code", {14'd0, err_code[0]}, 16'd2);
        check_lit("t3_long_cnt", {8'h00, err_cnt[0]}, 16'd2);

        // 4: bad pad nibble, checked vs unchecked instance
        send_frame(16'h1A50, 16);
        idle(4);
        check_lit("t4_pad_code", {14'd0, err_code[0]}, 16'd3);
        check_lit("t4_pad_data", {8'h00, rx_data[0]}, 16'h00FF);
        check_lit("t4_nopad_data", {8'h00, rx_data[1]}, 16'h00A5);
        check_lit("t4_nopad_good", good_cnt[1], 16'd4);

        // 5: reset in the middle of a frame, released with sync still low
        @(negedge clk);
        dac_sync = 1'b0;
        send_bits(16'h0770, 0, 8);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        send_bits(16'h0770, 8, 16);
        dac_sync = 1'b1;
        idle(3);
        send_frame(16'h0330, 16);
        idle(4);
        check_lit("t5_data", {8'h00, rx_data[0]}, 16'h0033);
        check_lit("t5_good", good_cnt[0], 16'd1);
        check_lit("t5_err", {8'h00, err_cnt[0]}, 16'd0);

        // 6: driver-style sawtooth, then error flood
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = 8'((16 + i) % 256);
            send_frame({4'h0, d, 4'h0}, 16);
        end
        idle(4);
        check_lit("t6_good", good_cnt[0], 16'd601);
        check_lit("t6_err", {8'h00, err_cnt[0]}, 16'd0);
        check_lit("t6_last_data", {8'h00, rx_data[0]}, 16'h0067);
        for (int i = 0; i < 300; i++) begin
            send_frame(16'hF000, 4);
        end
        idle(4);
        check_lit("t6_err_sat0", {8'h00, err_cnt[0]}, 16'h00FF);
        check_lit("t6_err_sat1", {8'h00, err_cnt[1]}, 16'h00FF);
        check_lit("t6_data_hold", {8'h00, rx_data[0]}, 16'h0067);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
